// File: rtl/input_1x1_scheduler.sv
// Input-buffer sequencer for the 1x1 convolution: streams a frame into the channel-packed
// BRAM, then drains it pixel-by-pixel through a 2-entry skid FIFO that hides BRAM read latency.
module input_1x1_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int IN_CHANNELS  = 3,
    parameter int IN_WIDTH     = 5,
    parameter int IN_HEIGHT    = 5,
    parameter int READ_LATENCY = 1,
    localparam int PIXELS = IN_WIDTH * IN_HEIGHT,
    localparam int DEPTH  = PIXELS * IN_CHANNELS,
    localparam int WA     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int RA     = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int PW     = DATA_WIDTH * IN_CHANNELS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [PW-1:0]         m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] bram_wr_data,
    output logic [WA-1:0]         bram_wr_addr,
    output logic                  bram_wr_en,
    output logic [RA-1:0]         bram_rd_addr,
    output logic                  bram_rd_en,
    input  logic [PW-1:0]         bram_rd_data
);

    localparam int RCW = $clog2(PIXELS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state;
    logic [WA-1:0]  wr_cnt;
    logic [RCW-1:0] rd_cnt;
    logic [PW-1:0]  fifo_head;
    logic [PW-1:0]  fifo_tail;
    logic [1:0]     count;
    logic           inflight;

    logic           pop;
    logic           push;
    logic           issue;
    logic           last_write;
    logic           last_pop;
    logic [2:0]     occupancy;

    assign s_ready      = (state == S_LOAD);
    assign busy         = (state == S_LOAD) || (state == S_DRAIN);
    assign done         = (state == S_DONE);
    assign bram_wr_en   = s_valid & s_ready;
    assign bram_wr_data = s_data;
    assign bram_wr_addr = wr_cnt;
    assign bram_rd_addr = rd_cnt[RA-1:0];
    assign bram_rd_en   = issue;
    assign m_valid      = (count != 2'd0);
    assign m_data       = fifo_head;
    assign pop          = m_valid & m_ready;

    // Read-issue and FIFO-push decisions; occupancy counts reads still in the BRAM pipeline.
    always_comb begin
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue      = (state == S_DRAIN) && (rd_cnt < RCW'(PIXELS)) && (occupancy < 3'd2);
        if (READ_LATENCY == 0) begin
            push = issue;
        end else begin
            push = inflight && (state == S_DRAIN);
        end
        last_write = bram_wr_en && (wr_cnt == WA'(DEPTH - 1));
        // Everything issued, nothing returning, one pixel left: this pop is the final one.
        last_pop   = pop && (rd_cnt == RCW'(PIXELS)) && (count == 2'd1) && !inflight;
    end

    // Frame sequencing and the write/read address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        wr_cnt <= '0;
                        rd_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (bram_wr_en) begin
                        wr_cnt <= wr_cnt + WA'(1);
                    end
                    if (last_write) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + RCW'(1);
                    end
                    if (last_pop) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tracks a read issued this cycle whose data returns next cycle; a reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= (READ_LATENCY != 0) && issue;
        end
    end

    // Two-entry output FIFO, head always presented on m_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_head <= '0;
            fifo_tail <= '0;
            count     <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        fifo_head <= bram_rd_data;
                    end else begin
                        fifo_tail <= bram_rd_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    fifo_head <= fifo_tail;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        fifo_head <= bram_rd_data;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= bram_rd_data;
                    end
                end
                default: begin
                    count <= count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_1x1_scheduler.sv
// Bench: READ_LATENCY=1 and READ_LATENCY=0 builds driven side by side, each against a
// frame-level scoreboard plus hand-computed pixel and timing expectations.
module tb_input_1x1_scheduler;

    localparam int PIXELS = 25;
    localparam int DEPTH  = 75;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        s_valid;
    logic        m_ready;
    logic [7:0]  s_data;

    logic        busy    [2];
    logic        done    [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic [23:0] m_data  [2];
    logic [7:0]  wr_data [2];
    logic [6:0]  wr_addr [2];
    logic [4:0]  rd_addr [2];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  fdat [DEPTH];
    int          ph [2], nwr [2], nissue [2], npop [2];
    int          d_cyc [2], fv_cyc [2], dn_cyc [2], dn_cnt [2];
    bit          frame_end [2];
    bit          stall_prev [2];
    logic [23:0] data_prev [2];
    logic [23:0] got [2][PIXELS];
    bit          armed = 1'b0;
    bit          after_rst = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : gi
        logic [7:0]  mem [DEPTH];
        logic [23:0] rd_q;
        logic [23:0] px;
        logic [23:0] rd_data;
        int          ra;

        input_1x1_scheduler #(.READ_LATENCY(g)) dut (
            .clk(clk), .rst(rst), .start(start), .busy(busy[g]), .done(done[g]),
            .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready[g]),
            .m_data(m_data[g]), .m_valid(m_valid[g]), .m_ready(m_ready),
            .bram_wr_data(wr_data[g]), .bram_wr_addr(wr_addr[g]), .bram_wr_en(wr_en[g]),
            .bram_rd_addr(rd_addr[g]), .bram_rd_en(rd_en[g]), .bram_rd_data(rd_data)
        );

        always_comb begin
            ra = int'(rd_addr[g]);
            px = (ra < PIXELS) ? {mem[3*ra+2], mem[3*ra+1], mem[3*ra]} : 24'h000000;
        end

        always @(posedge clk) begin
            if (wr_en[g] && (int'(wr_addr[g]) < DEPTH)) mem[wr_addr[g]] <= wr_data[g];
            if (rd_en[g]) rd_q <= px;
        end

        if (g == 0) begin : g_comb
            assign rd_data = px;
        end else begin : g_reg
            assign rd_data = rd_q;
        end
    end

    function automatic logic [23:0] exp_px(int p);
        return {fdat[3*p+2], fdat[3*p+1], fdat[3*p]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: check this cycle's outputs, then advance the frame-level model.
    always @(negedge clk) begin
        if (armed) begin
            for (int g = 0; g < 2; g++) begin
                if (after_rst) begin
                    check($sformatf("reset_outs_rl%0d", g),
                          {busy[g], done[g], s_ready[g], m_valid[g], wr_en[g], rd_en[g],
                           m_data[g], wr_addr[g], rd_addr[g]}, 64'd0);
                end
                check($sformatf("busy_rl%0d", g), busy[g], (ph[g] == 1 || ph[g] == 2));
                check($sformatf("s_ready_rl%0d", g), s_ready[g], (ph[g] == 1));
                check($sformatf("done_rl%0d", g), done[g], (ph[g] == 3));
                check($sformatf("wr_en_rl%0d", g), wr_en[g], (s_valid && ph[g] == 1));
                if (wr_en[g]) check($sformatf("wr_addr_rl%0d", g), wr_addr[g], nwr[g]);
                if (ph[g] != 2) check($sformatf("idle_rd_valid_rl%0d", g), {rd_en[g], m_valid[g]}, 2'b00);
                if (rd_en[g]) begin
                    check($sformatf("rd_addr_rl%0d", g), rd_addr[g], nissue[g]);
                    check($sformatf("rd_range_rl%0d", g), (nissue[g] < PIXELS), 1'b1);
                end
                check($sformatf("occupancy_rl%0d", g), (nissue[g] - npop[g] <= 2), 1'b1);
                if (stall_prev[g]) check($sformatf("stall_hold_rl%0d", g), {m_valid[g], m_data[g]}, {1'b1, data_prev[g]});
                if (m_valid[g] && m_ready) begin
                    check($sformatf("pixel%0d_rl%0d", npop[g], g), m_data[g], exp_px(npop[g] % PIXELS));
                    if (npop[g] < PIXELS) got[g][npop[g]] = m_data[g];
                end
            end
        end
        if (rst) begin
            armed = 1'b1;
            after_rst = 1'b1;
            for (int g = 0; g < 2; g++) begin
                ph[g] = 0; nwr[g] = 0; nissue[g] = 0; npop[g] = 0; stall_prev[g] = 1'b0;
            end
        end else if (armed) begin
            after_rst = 1'b0;
            for (int g = 0; g < 2; g++) begin
                stall_prev[g] = m_valid[g] && !m_ready;
                data_prev[g]  = m_data[g];
                case (ph[g])
                    0: if (start) begin ph[g] = 1; nwr[g] = 0; end
                    1: if (s_valid) begin
                        nwr[g]++;
                        if (nwr[g] == DEPTH) begin
                            ph[g] = 2; nissue[g] = 0; npop[g] = 0;
                            d_cyc[g] = cyc + 1; fv_cyc[g] = -1;
                        end
                    end
                    2: begin
                        if (m_valid[g] && fv_cyc[g] < 0) fv_cyc[g] = cyc;
                        if (rd_en[g]) nissue[g]++;
                        if (m_valid[g] && m_ready) begin
                            npop[g]++;
                            if (npop[g] == PIXELS) ph[g] = 3;
                        end
                    end
                    default: begin
                        dn_cyc[g] = cyc; dn_cnt[g]++; ph[g] = 0; frame_end[g] = 1'b1;
                    end
                endcase
            end
        end
    end

    task automatic load_frame(bit gaps, bit poke);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0; s_data = 8'hEE;
                @(posedge clk); #1;
            end
            s_valid = 1'b1; s_data = fdat[k]; start = poke && (k == 10);
            @(posedge clk); #1;
        end
        start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    endtask

    task automatic run_frame(bit gaps, bit rnd, bit poke);
        frame_end[0] = 1'b0; frame_end[1] = 1'b0;
        load_frame(gaps, poke);
        for (int i = 0; i < 400 && !(frame_end[0] && frame_end[1]); i++) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = poke && (i == 3);
            @(posedge clk); #1;
        end
        start = 1'b0; m_ready = 1'b0;
        check("frame_completes", {frame_end[0], frame_end[1]}, 2'b11);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        for (int g = 0; g < 2; g++) dn_cnt[g] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1: byte k = k, no gaps, m_ready held high.
        for (int k = 0; k < DEPTH; k++) fdat[k] = 8'(k);
        run_frame(1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("f1_px0_rl%0d", g), got[g][0], 24'h020100);
            check($sformatf("f1_px24_rl%0d", g), got[g][24], 24'h4A4948);
            check($sformatf("f1_first_valid_rl%0d", g), fv_cyc[g] - d_cyc[g], 1 + g);
            check($sformatf("f1_drain_len_rl%0d", g), dn_cyc[g] - d_cyc[g], PIXELS + 1 + g);
            check($sformatf("f1_done_count_rl%0d", g), dn_cnt[g], 1);
        end

        // Frame 2: new data, input gaps, random backpressure, start poked while busy.
        for (int k = 0; k < DEPTH; k++) fdat[k] = 8'(k * 7 + 3);
        run_frame(1'b1, 1'b1, 1'b1);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("f2_px5_rl%0d", g), got[g][5], 24'h7A736C);
            check($sformatf("f2_done_count_rl%0d", g), dn_cnt[g], 2);
        end

        // Frame 3: aborted by reset a few cycles into the drain, reads in flight.
        for (int k = 0; k < DEPTH; k++) fdat[k] = 8'(255 - k);
        load_frame(1'b0, 1'b0);
        m_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; m_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Frame 4: clean frame after the abort must carry no stale pixel.
        for (int k = 0; k < DEPTH; k++) fdat[k] = 8'(k) ^ 8'h55;
        run_frame(1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("f4_px0_rl%0d", g), got[g][0], 24'h575455);
            check($sformatf("f4_drain_len_rl%0d", g), dn_cyc[g] - d_cyc[g], PIXELS + 1 + g);
            check($sformatf("f4_done_count_rl%0d", g), dn_cnt[g], 3);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
